// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache package: line/beat geometry and the adaptor state encoding
// used by the cache pmem ports and the cacheline adaptor.
package cacheline_adaptor_pkg;

    localparam int S_LINE   = 256;
    localparam int S_BURST  = 64;
    localparam int N_BEATS  = S_LINE / S_BURST;
    localparam int CNT_W    = $clog2(N_BEATS);
    localparam int OFFSET_W = $clog2(S_LINE / 8);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        WRITE = ST_WRITE,
        RESP  = ST_RESP,
        GAP   = ST_GAP
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line read/write into a burst of 64-bit beats
// on the physical-memory bus, returning the line with a one-cycle line_resp.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        line_address,
    input  logic               line_read,
    input  logic               line_write,
    input  logic [S_LINE-1:0]  line_wdata,
    output logic [S_LINE-1:0]  line_rdata,
    output logic               line_resp,
    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,
    output logic [S_BURST-1:0] burst_wdata,
    input  logic [S_BURST-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(N_BEATS - 1);
    localparam logic [31:0]      OFFSET_MASK = 32'((64'd1 << OFFSET_W) - 64'd1);

    adaptor_state_t    state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [S_LINE-1:0] wdata_q;
    logic              beat_done;
    logic              last_beat;

    // Beats are only meaningful while a burst is open; stray responses elsewhere are dropped.
    assign beat_done = burst_resp && ((state == READ) || (state == WRITE));
    assign last_beat = beat_done && (beat_cnt == LAST_BEAT);

    assign burst_wdata = wdata_q[int'(beat_cnt) * S_BURST +: S_BURST];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            line_resp     <= 1'b0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_address <= 32'd0;
            wdata_q       <= '0;
        end else begin
            line_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_read) begin
                        state         <= READ;
                        burst_read    <= 1'b1;
                        burst_address <= line_address & ~OFFSET_MASK;
                    end else if (line_write) begin
                        state         <= WRITE;
                        burst_write   <= 1'b1;
                        burst_address <= line_address & ~OFFSET_MASK;
                        wdata_q       <= line_wdata;
                    end
                end
                READ, WRITE: begin
                    if (last_beat) begin
                        state       <= RESP;
                        burst_read  <= 1'b0;
                        burst_write <= 1'b0;
                        line_resp   <= 1'b1;
                    end
                end
                RESP:    state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The counter wraps to zero naturally on the last beat, which is the move into RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
        end else if (beat_done) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_rdata <= '0;
        end else if (burst_resp && (state == READ)) begin
            line_rdata[int'(beat_cnt) * S_BURST +: S_BURST] <= burst_rdata;
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed plus randomized bench for cacheline_adaptor; expected lines, beats
// and addresses are built from the transaction rules, not from DUT state.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic               clk;
    logic               rst;
    logic [31:0]        line_address;
    logic               line_read;
    logic               line_write;
    logic [S_LINE-1:0]  line_wdata;
    logic [S_LINE-1:0]  line_rdata;
    logic               line_resp;
    logic [31:0]        burst_address;
    logic               burst_read;
    logic               burst_write;
    logic [S_BURST-1:0] burst_wdata;
    logic [S_BURST-1:0] burst_rdata;
    logic               burst_resp;

    int assert_count = 0;
    int fail_count   = 0;
    logic [S_LINE-1:0] last_line = '0;

    cacheline_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_address  (line_address),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_wdata    (line_wdata),
        .line_rdata    (line_rdata),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] wdata);
        line_read    = rd;
        line_write   = wr;
        line_address = addr;
        line_wdata   = wdata;
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rdata"}, line_rdata, '0);
        checkOutput({tag, "_resp"}, line_resp, '0);
        checkOutput({tag, "_baddr"}, burst_address, '0);
        checkOutput({tag, "_bread"}, burst_read, '0);
        checkOutput({tag, "_bwrite"}, burst_write, '0);
        checkOutput({tag, "_bwdata"}, burst_wdata, '0);
    endtask

    // Called at a negedge; leaves the bench at the negedge two cycles after line_resp.
    task automatic runRead(input logic [31:0] addr, input logic [255:0] line, input logic [7:0] pattern,
                           input bit use_pattern, input bit also_write, input bit drop_req);
        logic [31:0] exp_addr;
        int k;
        int cyc;
        bit resp;
        exp_addr = addr & 32'hFFFF_FFE0;
        k = 0;
        cyc = 0;
        applyStimulus(1'b1, also_write, addr, randLine());
        burst_resp = 1'b0;
        @(negedge clk);
        checkOutput("rd_accept", burst_read, 1'b1);
        if (drop_req) applyStimulus(1'b0, 1'b0, $urandom, randLine());
        else line_address = $urandom;
        while (k < 4 && cyc < 100) begin
            checkOutput("rd_busy", {burst_read, burst_write, line_resp}, 3'b100);
            checkOutput("rd_addr", burst_address, exp_addr);
            resp = use_pattern ? pattern[cyc % 8] : 1'($urandom_range(0, 1));
            burst_resp  = resp;
            burst_rdata = resp ? line[k*64 +: 64] : {$urandom, $urandom};
            if (resp) k++;
            @(negedge clk);
            cyc++;
        end
        burst_resp = 1'b0;
        checkOutput("rd_beats", k, 4);
        checkOutput("rd_resp", line_resp, 1'b1);
        checkOutput("rd_rdata", line_rdata, line);
        checkOutput("rd_bread_low", {burst_read, burst_write}, 2'b00);
        @(negedge clk);
        checkOutput("rd_resp_once", line_resp, 1'b0);
        checkOutput("rd_rdata_hold", line_rdata, line);
        @(negedge clk);
        checkOutput("rd_gap_ignored", {burst_read, burst_write, line_resp}, 3'b000);
        applyStimulus(1'b0, 1'b0, 32'd0, '0);
        last_line = line;
    endtask

    task automatic runWrite(input logic [31:0] addr, input logic [255:0] wdata, input bit drop_req);
        logic [31:0] exp_addr;
        int k;
        int cyc;
        bit resp;
        exp_addr = addr & 32'hFFFF_FFE0;
        k = 0;
        cyc = 0;
        applyStimulus(1'b0, 1'b1, addr, wdata);
        burst_resp = 1'b0;
        @(negedge clk);
        checkOutput("wr_accept", {burst_read, burst_write}, 2'b01);
        applyStimulus(1'b0, !drop_req, $urandom, randLine());
        while (k < 4 && cyc < 100) begin
            checkOutput("wr_busy", {burst_read, burst_write, line_resp}, 3'b010);
            checkOutput("wr_addr", burst_address, exp_addr);
            checkOutput("wr_beat", burst_wdata, wdata[k*64 +: 64]);
            resp = 1'($urandom_range(0, 1));
            burst_resp  = resp;
            burst_rdata = {$urandom, $urandom};
            if (resp) k++;
            @(negedge clk);
            cyc++;
        end
        burst_resp = 1'b0;
        checkOutput("wr_beats", k, 4);
        checkOutput("wr_resp", line_resp, 1'b1);
        checkOutput("wr_bwrite_low", {burst_read, burst_write}, 2'b00);
        checkOutput("wr_rdata_untouched", line_rdata, last_line);
        @(negedge clk);
        checkOutput("wr_resp_once", line_resp, 1'b0);
        @(negedge clk);
        checkOutput("wr_gap_ignored", {burst_read, burst_write, line_resp}, 3'b000);
        applyStimulus(1'b0, 1'b0, 32'd0, '0);
    endtask

    initial begin
        logic [255:0] line;
        logic [255:0] stale;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, randLine());
        burst_resp  = 1'b1;
        burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;

        // Reset held with live requests and responses must keep everything quiet.
        repeat (3) @(negedge clk);
        checkAllZero("rst_hold");
        checkOutput("rst_state", dut.state, IDLE);
        rst = 1'b1;

        runRead(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                8'hFF, 1'b1, 1'b0, 1'b0);

        runRead(32'h0000_ABCD, {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                                64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000},
                8'h69, 1'b1, 1'b0, 1'b0);

        runWrite(32'h8000_0040, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 1'b0);

        runRead(32'h1234_5678, randLine(), 8'hFF, 1'b1, 1'b1, 1'b0);

        // Abort a read after two beats; the partial line must vanish with the reset.
        stale = randLine();
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, '0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = stale[i*64 +: 64];
            @(negedge clk);
        end
        burst_resp = 1'b0;
        rst = 1'b0;
        #1;
        checkAllZero("rst_mid");
        @(negedge clk);
        checkOutput("rst_mid_no_resp", line_resp, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, '0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_idle", {burst_read, burst_write, line_resp}, 3'b000);
        last_line = '0;
        runRead(32'h0000_2000, randLine(), 8'h00, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            line = randLine();
            if ($urandom_range(0, 1) == 1)
                runRead($urandom, line, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                runWrite($urandom, line, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
